// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central pipeline sequencer for the 5-stage core. Produces the write-enable
//   and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
//   It resolves three hazard sources, highest priority first:
//     1. memory freeze  - MEM-stage access issued but not yet acknowledged
//     2. taken branch   - resolved in EX, squashes IF/ID and ID/EX
//     3. load-use       - a load in EX feeds a register read in ID
//   Control block only; no datapath values pass through it.
//
// Optional feature:
//   PIPE_HAZARD_CTRL_PERF_EN - adds the stall_cyc and flush_cnt counters.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   op_id       in   [5:0] opcode in ID
//   rs_id       in   [4:0] rs field in ID
//   rt_id       in   [4:0] rt field in ID
//   op_ex       in   [5:0] opcode in EX
//   Ri_ex       in   [4:0] destination register in EX
//   ife_ex      in   branch taken, resolved in EX
//   op_mem      in   [5:0] opcode in MEM
//   mem_ready   in   data memory completes its access this cycle
//   pc_we       out  PC load enable
//   ifid_we     out  IF/ID register enable
//   ifid_flush  out  IF/ID loads a bubble
//   idex_flush  out  ID/EX loads a bubble
//   exmem_we    out  EX/MEM register enable
//   mem_req     out  data-memory access request
//   mem_err     out  sticky memory-timeout flag
//   state       out  [1:0] current FSM state (debug)
//   stall_cyc   out  [31:0] cycles with pc_we=0 (PERF_EN only)
//   flush_cnt   out  [31:0] branch flush events (PERF_EN only)
//
// Handshake: mem_req is high while MEM holds a load/store; the access is
// complete in any cycle where mem_req and mem_ready are both high. Until then
// the whole pipeline holds.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter int         MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [5:0]  op_ex,
    input  logic [4:0]  Ri_ex,
    input  logic        ife_ex,
    input  logic [5:0]  op_mem,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_we,
    output logic        mem_req,
    output logic        mem_err,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cyc,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2,
        MWAIT  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt, wait_cnt_d;
    logic       freeze;
    logic       branch;
    logic       load_use;
    logic       branch_fire;
    logic       err_set;

    // op_id is part of the ID-stage view but every opcode is treated as a
    // potential reader of rs/rt, so it does not qualify hazard detection.
    logic       unused_op_id;
    assign unused_op_id = ^op_id;

    assign state = state_q;

    // Hazard detection
    always_comb begin
        mem_req  = ~rst & ((op_mem == OP_LW) | (op_mem == OP_SW));
        freeze   = mem_req & ~mem_ready;
        // BFLUSH ignores ife_ex: the instruction in EX is the bubble we inserted.
        branch   = ife_ex & (state_q != BFLUSH);
        // Register 0 never carries a dependency. LSTALL does not re-detect,
        // which limits each load to one bubble.
        load_use = (op_ex == OP_LW) && (Ri_ex != 5'd0) &&
                   ((Ri_ex == rs_id) || (Ri_ex == rt_id)) &&
                   ((state_q == RUN) || (state_q == MWAIT));
    end

    // Next state and control outputs
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        branch_fire = 1'b0;
        state_d     = RUN;

        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            exmem_we   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
            state_d  = MWAIT;
        end else if (branch) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            branch_fire = 1'b1;
            state_d     = BFLUSH;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LSTALL;
        end
    end

    // Wait counter: counts frozen cycles spent in MWAIT, saturating at
    // MAX_WAIT; any unfrozen cycle clears it.
    always_comb begin
        wait_cnt_d = wait_cnt;
        err_set    = 1'b0;
        if (!freeze) begin
            wait_cnt_d = 8'd0;
        end else if (state_q == MWAIT) begin
            if (wait_cnt < MAX_W) begin
                wait_cnt_d = wait_cnt + 8'd1;
            end
            err_set = (wait_cnt_d == MAX_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_we && (stall_cyc != 32'hFFFF_FFFF)) begin
                stall_cyc <= stall_cyc + 32'd1;
            end
            if (branch_fire && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
